// File: rtl/fifo_pkg.sv
// Shared types and defaults for the FIFO read-drain block (buffer state encoding, default widths).
package fifo_pkg;
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } buf_state_e;

  localparam int DEF_WIDTH     = 8;
  localparam int DEF_BURST_LEN = 4;
endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry in-order skid buffer; the head entry drives the stream, the tail absorbs one word of slack.
module fifo_skid_buf
  import fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output buf_state_e       o_state
);
  buf_state_e       r_state;
  buf_state_e       w_nxt;
  logic [WIDTH-1:0] r_head;
  logic [WIDTH-1:0] r_tail;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= EMPTY;
    else          r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      EMPTY:   if (i_push) w_nxt = ONE;
      ONE: begin
        if (i_push && !i_pop)      w_nxt = TWO;
        else if (!i_push && i_pop) w_nxt = EMPTY;
      end
      TWO:     if (!i_push && i_pop) w_nxt = ONE;
      default: w_nxt = EMPTY;
    endcase
  end

  // Push into TWO without a pop cannot happen: the read side never over-issues.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_head <= '0;
      r_tail <= '0;
    end else begin
      case (r_state)
        EMPTY: if (i_push) r_head <= i_data;
        ONE: begin
          if (i_push && i_pop) r_head <= i_data;
          else if (i_push)     r_tail <= i_data;
        end
        TWO: if (i_pop) begin
          r_head <= r_tail;
          if (i_push) r_tail <= i_data;
        end
        default: ;
      endcase
    end
  end

  assign o_valid = (r_state != EMPTY);
  assign o_data  = r_head;
  assign o_state = r_state;
endmodule

// File: rtl/fifo_rd_drain.sv
// Drains a FIFO with 1-cycle read latency into a valid/ready stream with burst m_last marking.
// Optional statistics outputs (rd_count, stall_seen) are built when FIFO_RD_DRAIN_STATS_EN is defined.
module fifo_rd_drain
  import fifo_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int BURST_LEN = DEF_BURST_LEN
) (
  input  logic             r_clk,
  input  logic             rst_n,
  input  logic             fifo_empty,
  output logic             fifo_rd_en,
  input  logic [WIDTH-1:0] fifo_rdata,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_last
`ifdef FIFO_RD_DRAIN_STATS_EN
  ,
  output logic [31:0]      rd_count,
  output logic             stall_seen
`endif
);
  localparam int CW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  logic [1:0]    r_rel_pipe;
  logic          r_inflight;
  logic [CW-1:0] r_beat;
  logic          w_xfer;
  logic [2:0]    w_occ;
  buf_state_e    w_state;

  fifo_skid_buf #(.WIDTH(WIDTH)) u_buf (
    .i_clk   (r_clk),
    .i_rst_n (rst_n),
    .i_push  (r_inflight),
    .i_data  (fifo_rdata),
    .i_pop   (w_xfer),
    .o_valid (m_valid),
    .o_data  (m_data),
    .o_state (w_state)
  );

  assign w_xfer = m_valid & m_ready;

  // Occupancy as seen after this edge: a same-cycle transfer frees its slot for a new read.
  assign w_occ = {1'b0, w_state} + {2'b00, r_inflight} - {2'b00, w_xfer};

  // r_rel_pipe holds off reads until a full cycle after reset release.
  assign fifo_rd_en = r_rel_pipe[1] & ~fifo_empty & (w_occ < 3'd2);
  assign m_last     = m_valid & (r_beat == CW'(BURST_LEN - 1));

  always_ff @(posedge r_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rel_pipe <= '0;
      r_inflight <= 1'b0;
      r_beat     <= '0;
    end else begin
      r_rel_pipe <= {r_rel_pipe[0], 1'b1};
      r_inflight <= fifo_rd_en;
      if (w_xfer) r_beat <= (r_beat == CW'(BURST_LEN - 1)) ? '0 : r_beat + 1'b1;
    end
  end

`ifdef FIFO_RD_DRAIN_STATS_EN
  logic [31:0] r_rd_count;
  logic        r_stall_seen;

  always_ff @(posedge r_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_count   <= '0;
      r_stall_seen <= 1'b0;
    end else begin
      if (w_xfer) r_rd_count <= r_rd_count + 32'd1;
      if (m_valid && !m_ready) r_stall_seen <= 1'b1;
    end
  end

  assign rd_count   = r_rd_count;
  assign stall_seen = r_stall_seen;
`endif
endmodule

// File: tb/tb_fifo_rd_drain.sv
// Randomized bench for fifo_rd_drain against a queue-based model of the read/stream contract.
module tb_fifo_rd_drain;
  localparam int W  = 8;
  localparam int BL = 4;

  logic         r_clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         fifo_empty = 1'b1;
  logic         fifo_rd_en;
  logic [W-1:0] fifo_rdata = '0;
  logic         m_valid;
  logic         m_ready = 1'b0;
  logic [W-1:0] m_data;
  logic         m_last;
`ifdef FIFO_RD_DRAIN_STATS_EN
  logic [31:0]  rd_count;
  logic         stall_seen;
`endif

  fifo_rd_drain #(.WIDTH(W), .BURST_LEN(BL)) dut (
    .r_clk      (r_clk),
    .rst_n      (rst_n),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .fifo_rdata (fifo_rdata),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last)
`ifdef FIFO_RD_DRAIN_STATS_EN
    ,
    .rd_count   (rd_count),
    .stall_seen (stall_seen)
`endif
  );

  always #5 r_clk = ~r_clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Model: fq = FIFO contents, oq = words read but not yet transferred (with the cycle they may appear).
  typedef struct { logic [W-1:0] d; int avail; } ent_t;
  logic [W-1:0] fq[$];
  ent_t         oq[$];
  logic [W-1:0] xd[$];
  int           xc[$];
  bit           pend = 0;
  logic [W-1:0] pend_d = '0;
  int           cyc = 0, rel = 0, beats = 0, nxfer = 0, nrd = 0;
  logic [31:0]  cnt_m = '0;
  bit           stall_m = 0;

  task automatic step(input bit rdy);
    bit   ev, el, er, xf;
    ent_t e;
    @(negedge r_clk);
    cyc++;
    if (rel < 2) rel++;
    fifo_rdata = pend ? pend_d : W'($urandom);
    fifo_empty = (fq.size() == 0);
    m_ready    = rdy;
    #1;
    ev = (oq.size() > 0) && (oq[0].avail <= cyc);
    xf = ev && rdy;
    er = (rel >= 2) && (fq.size() > 0) && ((oq.size() - int'(xf)) < 2);
    el = ev && ((beats % BL) == BL - 1);
    chk("m_valid", 32'(m_valid), 32'(ev));
    chk("rd_en", 32'(fifo_rd_en), 32'(er));
    chk("m_last", 32'(m_last), 32'(el));
    if (ev) chk("m_data", 32'(m_data), 32'(oq[0].d));
`ifdef FIFO_RD_DRAIN_STATS_EN
    chk("rd_count", rd_count, cnt_m);
    chk("stall_seen", 32'(stall_seen), 32'(stall_m));
`endif
    if (xf) begin
      void'(oq.pop_front());
      beats++; nxfer++; cnt_m++;
      xd.push_back(m_data);
      xc.push_back(cyc);
    end
    if (ev && !rdy) stall_m = 1;
    pend = 0;
    if (fifo_rd_en === 1'b1 && fq.size() > 0) begin
      nrd++;
      pend   = 1;
      pend_d = fq.pop_front();
      e.d = pend_d; e.avail = cyc + 2;
      oq.push_back(e);
    end
  endtask

  task automatic do_reset();
    @(negedge r_clk);
    rst_n = 1'b0;
    #1;
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
    chk("rst_m_last", 32'(m_last), 32'd0);
    chk("rst_m_data", 32'(m_data), 32'd0);
`ifdef FIFO_RD_DRAIN_STATS_EN
    chk("rst_rd_count", rd_count, 32'd0);
    chk("rst_stall", 32'(stall_seen), 32'd0);
`endif
    oq.delete(); pend = 0; beats = 0; cnt_m = '0; stall_m = 0; rel = 0;
    @(negedge r_clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [W-1:0] exp_next;
    do_reset();

    // Preloaded 4-word burst at full rate.
    fq = '{8'h11, 8'h22, 8'h33, 8'h44};
    xc.delete(); xd.delete();
    repeat (12) step(1'b1);
    chk("burst_n", 32'(xc.size()), 32'd4);
    if (xc.size() == 4) begin
      chk("burst_consec", 32'(xc[3] - xc[0]), 32'd3);
      chk("burst_last_word", 32'(xd[3]), 32'h44);
    end

    // Backpressure: only two reads may be outstanding.
    do_reset();
    for (int i = 0; i < 8; i++) fq.push_back(W'(8'hA0 + i));
    nrd = 0; nxfer = 0;
    repeat (10) step(1'b0);
    chk("hold_reads", 32'(nrd), 32'd2);
    repeat (14) step(1'b1);
    chk("hold_drained", 32'(nxfer), 32'd8);

    // Alternating ready over 12 words.
    do_reset();
    for (int i = 1; i <= 12; i++) fq.push_back(W'(i));
    nxfer = 0; xd.delete();
    for (int i = 0; i < 40; i++) step(bit'(i % 2 == 0));
    chk("toggle_n", 32'(nxfer), 32'd12);
    if (xd.size() == 12) chk("toggle_last", 32'(xd[11]), 32'd12);

    // Permanently empty FIFO.
    do_reset();
    nrd = 0;
    repeat (20) step(bit'($urandom_range(0, 1)));
    chk("empty_rd", 32'(nrd), 32'd0);

    // Reset with a read in flight and the buffer loaded.
    do_reset();
    for (int i = 0; i < 8; i++) fq.push_back(W'(8'hC0 + i));
    repeat (6) step(1'b0);
    step(1'b1);
    do_reset();
    exp_next = fq[0];
    xd.delete();
    repeat (8) step(1'b1);
    if (xd.size() > 0) chk("post_rst_word", 32'(xd[0]), 32'(exp_next));
    else chk("post_rst_any", 32'(xd.size()), 32'd1);

`ifdef FIFO_RD_DRAIN_STATS_EN
    // Five transfers with one stall cycle.
    do_reset();
    fq.delete();
    for (int i = 0; i < 5; i++) fq.push_back(W'(8'h50 + i));
    for (int i = 0; i < 14; i++) step(bit'(i != 3));
    chk("stats_cnt", rd_count, 32'd5);
    chk("stats_stall", 32'(stall_seen), 32'd1);
`endif

    // Random traffic with occasional resets.
    do_reset();
    fq.delete();
    for (int i = 0; i < 500; i++) begin
      if (fq.size() < 6 && $urandom_range(0, 1) == 1) fq.push_back(W'($urandom));
      if ($urandom_range(0, 99) == 0) do_reset();
      else step(bit'($urandom_range(0, 3) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
